// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for a 32-bit floating-point ALU.
// Issues one command, waits a per-opcode latency, returns the result with its tag.
module alu_op_sequencer #(
   parameter int ADD_LAT = 2,
   parameter int SUB_LAT = 2,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 16,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [1:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [1:0]       alu_op,
   input  logic [31:0]      alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_dz,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_cnt_zero;
   logic [7:0]       w_lat;
   logic [7:0]       r_cnt;
   logic [31:0]      r_alu_a;
   logic [31:0]      r_alu_b;
   logic [1:0]       r_alu_op;
   logic [31:0]      r_rsp_data;
   logic [TAG_W-1:0] r_rsp_tag;
   logic             r_rsp_dz;

   assign w_accept   = cmd_valid && (r_state == S_IDLE);
   assign w_cnt_zero = (r_cnt == 8'd0);

   always_comb begin
      w_lat = 8'd0;
      unique case (cmd_op)
         2'b00: w_lat = 8'(ADD_LAT);
         2'b01: w_lat = 8'(SUB_LAT);
         2'b10: w_lat = 8'(MUL_LAT);
         2'b11: w_lat = 8'(DIV_LAT);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (cmd_valid)  w_next = S_WAIT;
         S_WAIT:  if (w_cnt_zero) w_next = S_RESP;
         S_RESP:  if (rsp_ready)  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (r_state == S_IDLE);
      rsp_valid = (r_state == S_RESP);
      busy      = (r_state != S_IDLE);
   end

   // Operands stay frozen from accept until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_op   <= '0;
         r_rsp_data <= '0;
         r_rsp_tag  <= '0;
         r_rsp_dz   <= 1'b0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_alu_a   <= cmd_a;
         r_alu_b   <= cmd_b;
         r_alu_op  <= cmd_op;
         r_rsp_tag <= cmd_tag;
         r_rsp_dz  <= (cmd_op == 2'b11) && (cmd_b[30:0] == 31'd0);
         r_cnt     <= w_lat;
      end else if (r_state == S_WAIT) begin
         if (!w_cnt_zero) r_cnt      <= r_cnt - 8'd1;
         else             r_rsp_data <= alu_c;
      end
   end

   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign alu_op   = r_alu_op;
   assign rsp_data = r_rsp_data;
   assign rsp_tag  = r_rsp_tag;
   assign rsp_dz   = r_rsp_dz;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: stub ALU with latency, scoreboard of expected responses.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [1:0]  cmd_op = '0;
   logic [3:0]  cmd_tag = '0;
   logic [31:0] alu_a, alu_b, alu_c;
   logic [1:0]  alu_op;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic        rsp_dz;
   logic        busy;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [1:0]  op;
      logic [3:0]  tag;
      logic        dz;
      int          acc_edge;
   } exp_t;

   exp_t sb[$];
   int   errs = 0;
   int   checks = 0;
   int   edge_cnt = 0;
   int   age = 0;
   bit   acc_next = 0;
   int   last_hs_edge = 0;
   int   last_acc_edge = 0;
   int   rise_cnt = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_tag;
   logic        prev_dz;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input logic [1:0] op);
      case (op)
         2'b00:   return 2;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 16;
      endcase
   endfunction

   // Stub ALU: correct result only once operands have been held for the latency.
   function automatic logic [31:0] alu_model(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [1:0] op);
      case ({op, a, b})
         {2'b00, 32'h3F800000, 32'h40000000}: return 32'h40400000;
         {2'b01, 32'h40400000, 32'h3F800000}: return 32'h40000000;
         {2'b10, 32'h40000000, 32'h40400000}: return 32'h40C00000;
         {2'b11, 32'h3F800000, 32'h80000000}: return 32'hFF800000;
         {2'b11, 32'h3F800000, 32'h40000000}: return 32'h3F000000;
         default: return a ^ b;
      endcase
   endfunction

   always_comb begin
      alu_c = 32'hDEADBEEF;
      if (age >= lat_of(alu_op)) alu_c = alu_model(alu_a, alu_b, alu_op);
   end

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (acc_next)       age <= 0;
      else if (age < 255) age <= age + 1;
   end

   always @(negedge clk) begin
      acc_next = cmd_valid && cmd_ready && !rst;
      if (rst) begin
         sb.delete();
         prev_valid = 1'b0;
      end else begin
         chk("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, !busy});
         if (busy && !rsp_valid && sb.size() > 0) begin
            chk("hold_a", alu_a, sb[0].a);
            chk("hold_b", alu_b, sb[0].b);
            chk("hold_op", {30'd0, alu_op}, {30'd0, sb[0].op});
         end
         if (rsp_valid && !prev_valid) begin
            rise_cnt++;
            if (sb.size() > 0)
               chk("latency", edge_cnt - sb[0].acc_edge,
                   lat_of(sb[0].op) + 1);
         end
         if (rsp_valid && prev_valid) begin
            chk("bp_data", rsp_data, prev_data);
            chk("bp_tag", {28'd0, rsp_tag}, {28'd0, prev_tag});
            chk("bp_dz", {31'd0, rsp_dz}, {31'd0, prev_dz});
         end
         if (rsp_valid && rsp_ready) begin
            last_hs_edge = edge_cnt + 1;
            if (sb.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_data", rsp_data, e.c);
               chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
               chk("rsp_dz", {31'd0, rsp_dz}, {31'd0, e.dz});
            end
         end
         prev_valid = rsp_valid && !rsp_ready;
         prev_data  = rsp_data;
         prev_tag   = rsp_tag;
         prev_dz    = rsp_dz;
      end
   end

   // Leaves cmd_valid high; caller drops it when the stream ends.
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [3:0] tag,
                       input logic [31:0] c, input logic dz);
      exp_t e;
      bit   ok = 0;
      cmd_valid = 1'b1;
      cmd_a = a;
      cmd_b = b;
      cmd_op = op;
      cmd_tag = tag;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("send_timeout", 0, 1);
         return;
      end
      e.a = a; e.b = b; e.c = c; e.op = op; e.tag = tag; e.dz = dz;
      e.acc_edge = edge_cnt + 1;
      last_acc_edge = e.acc_edge;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_valid", {31'd0, rsp_valid}, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_data", rsp_data, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rst_ready", {31'd0, cmd_ready}, 1);
      @(posedge clk);
      #1;

      send(32'h3F800000, 32'h40000000, 2'b00, 4'd5, 32'h40400000, 1'b0);
      cmd_valid = 1'b0;
      wait_done();
      chk("ready_after_hs", edge_cnt - last_hs_edge >= 1 ? 1 : 0, 1);

      send(32'h40000000, 32'h40400000, 2'b10, 4'd1, 32'h40C00000, 1'b0);
      send(32'h40400000, 32'h3F800000, 2'b01, 4'd2, 32'h40000000, 1'b0);
      cmd_valid = 1'b0;
      wait_done();

      send(32'h3F800000, 32'h80000000, 2'b11, 4'd12, 32'hFF800000, 1'b1);
      send(32'h3F800000, 32'h40000000, 2'b11, 4'd13, 32'h3F000000, 1'b0);
      cmd_valid = 1'b0;
      wait_done();

      // Backpressure with a competing command pending.
      rsp_ready = 1'b0;
      send(32'h3F800000, 32'h40000000, 2'b00, 4'd7, 32'h40400000, 1'b0);
      cmd_a = 32'h40000000;
      cmd_b = 32'h40400000;
      cmd_op = 2'b10;
      cmd_tag = 4'd8;
      for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
      chk("bp_reached", {31'd0, rsp_valid}, 1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_ready", {31'd0, cmd_ready}, 0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      send(32'h40000000, 32'h40400000, 2'b10, 4'd8, 32'h40C00000, 1'b0);
      chk("bp_acc_edge", last_acc_edge - last_hs_edge, 1);
      cmd_valid = 1'b0;
      wait_done();

      // Abort a divide mid-WAIT.
      send(32'h3F800000, 32'h40000000, 2'b11, 4'd9, 32'h3F000000, 1'b0);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_valid", {31'd0, rsp_valid}, 0);
      chk("abort_a", alu_a, 0);
      chk("abort_b", alu_b, 0);
      chk("abort_op", {30'd0, alu_op}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rise_cnt = 0;
      repeat (30) @(posedge clk);
      #1 chk("abort_no_rsp", rise_cnt, 0);
      send(32'h3F800000, 32'h40000000, 2'b00, 4'd6, 32'h40400000, 1'b0);
      cmd_valid = 1'b0;
      wait_done();

      // Back-to-back stream, one per opcode.
      rise_cnt = 0;
      send(32'h3F800000, 32'h40000000, 2'b00, 4'd0, 32'h40400000, 1'b0);
      send(32'h40400000, 32'h3F800000, 2'b01, 4'd1, 32'h40000000, 1'b0);
      send(32'h40000000, 32'h40400000, 2'b10, 4'd2, 32'h40C00000, 1'b0);
      send(32'h3F800000, 32'h40000000, 2'b11, 4'd3, 32'h3F000000, 1'b0);
      cmd_valid = 1'b0;
      wait_done();
      chk("b2b_count", rise_cnt, 4);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
